descriptor_fetch: RTL

Downstream consumer of the descriptor memory: walks a contiguous, wrapping range of descriptor slots, reads each entry through the memory's registered read port, and presents each descriptor on a valid/ready stream to the DMA datapath. Optionally drops null descriptors (payload_ptr == 0). While the walk is running, the block owns the memory's shared address port; busy_o is the arbitration flag for the write path.

---
 rtl/dma_desc_pkg.sv | 24 ++
 rtl/descriptor_fetch_if.sv | 45 ++++
 rtl/desc_out_slice.sv | 24 ++
 rtl/descriptor_fetch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dma_desc_pkg.sv
// Shared descriptor definitions for the descriptor memory and its fetch engine.
package dma_desc_pkg;

    localparam int unsigned NUM_DESCRIPTORS_DEFAULT = 16;

    typedef struct packed {
        logic [15:0] src_address;
        logic [15:0] dst_address;
        logic [31:0] payload_ptr;
    } descriptor_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    // A null descriptor carries no payload and may be dropped by the fetcher.
    function automatic logic is_null_desc(input descriptor_t d);
        return d.payload_ptr == '0;
    endfunction

endpackage

// File: rtl/descriptor_fetch_if.sv
// Descriptor memory read port plus the outgoing descriptor stream.
interface descriptor_fetch_if
    import dma_desc_pkg::*;
#(
    parameter int unsigned IDX_W = $clog2(NUM_DESCRIPTORS_DEFAULT)
);
    logic [IDX_W-1:0] mem_addr_o;
    logic [15:0]      mem_src_i;
    logic [15:0]      mem_dst_i;
    logic [31:0]      mem_ptr_i;

    logic             desc_valid_o;
    logic             desc_ready_i;
    logic [15:0]      desc_src_o;
    logic [15:0]      desc_dst_o;
    logic [31:0]      desc_ptr_o;
    logic [IDX_W-1:0] desc_idx_o;

    modport master (
        output mem_addr_o,
        input  mem_src_i,
        input  mem_dst_i,
        input  mem_ptr_i,
        output desc_valid_o,
        input  desc_ready_i,
        output desc_src_o,
        output desc_dst_o,
        output desc_ptr_o,
        output desc_idx_o
    );

    modport slave (
        input  mem_addr_o,
        output mem_src_i,
        output mem_dst_i,
        output mem_ptr_i,
        input  desc_valid_o,
        output desc_ready_i,
        input  desc_src_o,
        input  desc_dst_o,
        input  desc_ptr_o,
        input  desc_idx_o
    );

endinterface

// File: rtl/desc_out_slice.sv
// Output holding register for one descriptor; loads only when load_i is high.
module desc_out_slice
    import dma_desc_pkg::*;
(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        load_i,
    input  descriptor_t desc_i,
    output descriptor_t desc_o
);

    descriptor_t desc_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            desc_q <= '0;
        end else if (load_i) begin
            desc_q <= desc_i;
        end
    end

    assign desc_o = desc_q;

endmodule

// File: rtl/descriptor_fetch.sv
// Walks a wrapping range of descriptor slots through a registered-read memory and
// streams each descriptor out on valid/ready, optionally dropping null entries.
module descriptor_fetch
    import dma_desc_pkg::*;
#(
    parameter int unsigned NUM_DESCRIPTORS = NUM_DESCRIPTORS_DEFAULT,
    parameter int unsigned IDX_W           = $clog2(NUM_DESCRIPTORS),
    parameter bit          SKIP_NULL       = 1'b1
) (
    input  logic               clk_i,
    input  logic               resetn_i,
    input  logic               start_i,
    input  logic [IDX_W-1:0]   first_idx_i,
    input  logic [IDX_W:0]     count_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    descriptor_fetch_if.master bus
);

    localparam logic [IDX_W:0] NumDesc = (IDX_W + 1)'(NUM_DESCRIPTORS);
    localparam logic [IDX_W:0] OneLeft = (IDX_W + 1)'(1);

    fetch_state_t     state_q, state_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic [IDX_W:0]   remaining_q, remaining_d;
    logic [IDX_W-1:0] out_idx_q;
    logic             done_q, done_d;
    logic             load;
    logic             advance;
    descriptor_t      mem_desc;
    descriptor_t      out_desc;

    assign mem_desc = '{
        src_address: bus.mem_src_i,
        dst_address: bus.mem_dst_i,
        payload_ptr: bus.mem_ptr_i
    };

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    if (count_i == '0) begin
                        // Empty walk completes without touching the memory.
                        done_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cur_idx_d   = first_idx_i;
                        remaining_d = (count_i > NumDesc) ? NumDesc : count_i;
                    end
                end
            end
            REQ: begin
                state_d = CAPT;
            end
            CAPT: begin
                if (SKIP_NULL && is_null_desc(mem_desc)) begin
                    advance = 1'b1;
                end else begin
                    load    = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.desc_ready_i) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            remaining_d = remaining_q - 1'b1;
            cur_idx_d   = cur_idx_q + 1'b1;
            if (remaining_q == OneLeft) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = REQ;
            end
        end

        // Abort overrides everything, including a completing handshake's done pulse.
        if (abort_i && (state_q != IDLE)) begin
            state_d     = IDLE;
            cur_idx_d   = cur_idx_q;
            remaining_d = remaining_q;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= IDLE;
            cur_idx_q   <= '0;
            remaining_q <= '0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_idx_q   <= cur_idx_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            if (load) begin
                out_idx_q <= cur_idx_q;
            end
        end
    end

    desc_out_slice u_out_slice (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .load_i   (load),
        .desc_i   (mem_desc),
        .desc_o   (out_desc)
    );

    assign bus.mem_addr_o   = (state_q == IDLE) ? '0 : cur_idx_q;
    assign bus.desc_valid_o = (state_q == OUT);
    assign bus.desc_src_o   = out_desc.src_address;
    assign bus.desc_dst_o   = out_desc.dst_address;
    assign bus.desc_ptr_o   = out_desc.payload_ptr;
    assign bus.desc_idx_o   = out_idx_q;

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule
